// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: streams a program into IMEM, holds the CPU in reset, then watches for halt or timeout.
// Build macro BOOT_CTRL_CHECKSUM_EN enables the load_csum accumulator (tied to 0 otherwise).
module cpu_boot_ctrl #(
  parameter int unsigned PC_WIDTH       = 12,
  parameter int unsigned OP_LENGTH      = 32,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned HALT_CYCLES    = 8,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [OP_LENGTH-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 imem_we,
  output logic [PC_WIDTH-1:0]  imem_addr,
  output logic [OP_LENGTH-1:0] imem_wdata,
  output logic                 cpu_rst,
  input  logic [PC_WIDTH-1:0]  cpu_pc,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 overflow,
  output logic [PC_WIDTH-2:0]  word_count,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [OP_LENGTH-1:0] load_csum
);

  localparam int unsigned IDX_W  = PC_WIDTH - 2;
  localparam int unsigned WC_W   = PC_WIDTH - 1;
  localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned HCNT_W = $clog2(HALT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RESET   = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4,
    S_TIMEOUT = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [RCNT_W-1:0]    rst_cnt;
  logic [HCNT_W-1:0]    stable;
  logic [PC_WIDTH-1:0]  prev_pc;
  logic                 first_run;

  logic                 accept_c;
  logic                 start_ok_c;
  logic                 last_slot_c;
  logic                 halt_c;
  logic                 tmo_c;
  logic [CNT_WIDTH-1:0] cnt_inc_c;

  // Handshake, halt and watchdog conditions
  always_comb begin
    start_ok_c  = start && (state inside {S_IDLE, S_DONE, S_TIMEOUT, S_ERROR});
    accept_c    = ld_valid && (state == S_LOAD);
    last_slot_c = (idx == {IDX_W{1'b1}});
    cnt_inc_c   = (cycle_count == {CNT_WIDTH{1'b1}}) ? cycle_count
                                                      : cycle_count + CNT_WIDTH'(1);
    halt_c      = !first_run && (cpu_pc == prev_pc) &&
                  (stable == HCNT_W'(HALT_CYCLES - 1));
    tmo_c       = (TIMEOUT_CYCLES != 0) && (cnt_inc_c == CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_TIMEOUT, S_ERROR: begin
        if (start_ok_c) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept_c) begin
          if (ld_last)          state_nxt = S_RESET;
          else if (last_slot_c) state_nxt = S_ERROR;
        end
      end
      S_RESET: begin
        if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (halt_c)     state_nxt = S_DONE;
        else if (tmo_c) state_nxt = S_TIMEOUT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  assign busy = (state inside {S_LOAD, S_RESET, S_RUN});

  // Registered outputs, IMEM write port and run-time counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_ready    <= 1'b0;
      cpu_rst     <= 1'b1;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      word_count  <= '0;
      cycle_count <= '0;
      idx         <= '0;
      rst_cnt     <= '0;
      stable      <= '0;
      prev_pc     <= '0;
      first_run   <= 1'b0;
    end else begin
      ld_ready <= (state_nxt == S_LOAD);
      cpu_rst  <= (state_nxt != S_RUN);
      imem_we  <= accept_c;

      if (start_ok_c) begin
        done        <= 1'b0;
        timeout     <= 1'b0;
        overflow    <= 1'b0;
        word_count  <= '0;
        cycle_count <= '0;
        idx         <= '0;
        imem_addr   <= '0;
      end

      if (accept_c) begin
        imem_addr  <= {idx, 2'b00};
        imem_wdata <= ld_data;
        idx        <= idx + IDX_W'(1);
        word_count <= word_count + WC_W'(1);
        if (!ld_last && last_slot_c) overflow <= 1'b1;
        if (ld_last) begin
          rst_cnt     <= '0;
          cycle_count <= '0;
        end
      end

      if (state == S_RESET) begin
        rst_cnt <= rst_cnt + RCNT_W'(1);
        if (state_nxt == S_RUN) begin
          first_run <= 1'b1;
          stable    <= '0;
        end
      end

      // First RUN cycle only captures the PC; later cycles count repeats
      if (state == S_RUN) begin
        cycle_count <= cnt_inc_c;
        first_run   <= 1'b0;
        prev_pc     <= cpu_pc;
        if (first_run || (cpu_pc != prev_pc))
          stable <= HCNT_W'(1);
        else if (stable != {HCNT_W{1'b1}})
          stable <= stable + HCNT_W'(1);
        if (state_nxt == S_DONE)    done    <= 1'b1;
        if (state_nxt == S_TIMEOUT) timeout <= 1'b1;
      end
    end
  end

`ifdef BOOT_CTRL_CHECKSUM_EN
  logic [OP_LENGTH-1:0] csum;

  // Running modulo-2^OP_LENGTH sum of accepted words
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            csum <= '0;
    else if (start_ok_c) csum <= '0;
    else if (accept_c)   csum <= csum + ld_data;
  end

  assign load_csum = csum;
`else
  assign load_csum = '0;
`endif

endmodule
